// File: rtl/collective_controller.sv
// Controller endpoint of the node command protocol: queues host collectives,
// broadcasts op/size words to all nodes, tracks node readiness and reports completion latency.
module collective_controller #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 128,
  parameter int unsigned D     = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_op,
  input  logic [31:0]          cmd_size,
  input  logic [N-1:0]         node_ivalid,
  input  logic [128*N-1:0]     node_idata,
  output logic [N-1:0]         node_ovalid,
  output logic [0:128*N-1]     node_odata,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          done_op,
  output logic [31:0]          done_cycles,
  output logic [7:0]           err_count,
  output logic                 dup_err
);

  localparam int unsigned WORD_W      = 128;
  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW          = AW + 1;
  localparam int unsigned CHUNK_BYTES = N * W / 8;
  localparam logic [32:0] MAX_BYTES   = 33'(CHUNK_BYTES) << D;

  typedef enum logic [1:0] {
    S_COLLECT   = 2'd0,
    S_IDLE      = 2'd1,
    S_SEND_SIZE = 2'd2,
    S_WAIT      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   fifo_op_q   [DEPTH];
  logic [31:0]   fifo_op_d   [DEPTH];
  logic [31:0]   fifo_size_q [DEPTH];
  logic [31:0]   fifo_size_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          cmd_ready_q, cmd_ready_d;

  logic [N-1:0]         flags_q, flags_d;
  logic                 first_pass_q, first_pass_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          done_op_q, done_op_d;
  logic [31:0]          done_cycles_q, done_cycles_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 dup_err_q, dup_err_d;
  logic [31:0]          cycles_q, cycles_d;
  logic [31:0]          cur_op_q, cur_op_d;
  logic [31:0]          cur_size_q, cur_size_d;
  logic [N-1:0]         node_ovalid_q, node_ovalid_d;
  logic [0:128*N-1]     node_odata_q, node_odata_d;

  logic        push, pop, fifo_empty, head_valid;
  logic [31:0] head_op, head_size;
  logic        idata_unused;

  assign idata_unused = ^node_idata;

  assign push       = cmd_valid && cmd_ready_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head_op    = fifo_op_q[rd_ptr_q[AW-1:0]];
  assign head_size  = fifo_size_q[rd_ptr_q[AW-1:0]];

  // Command legality: known op, whole number of portions, at most 2**D portions per node
  assign head_valid = (head_op < 32'd2) && (head_size != 32'd0)
                   && ((head_size % 32'(CHUNK_BYTES)) == 32'd0)
                   && ({1'b0, head_size} <= MAX_BYTES);

  // Command FIFO pointers and storage
  always_comb begin
    fifo_op_d   = fifo_op_q;
    fifo_size_d = fifo_size_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    if (push) begin
      fifo_op_d[wr_ptr_q[AW-1:0]]   = cmd_op;
      fifo_size_d[wr_ptr_q[AW-1:0]] = cmd_size;
    end
    cmd_ready_d = (PW'(wr_ptr_d - rd_ptr_d) != PW'(DEPTH));
  end

  // Protocol FSM: next state, flags, counters and node outputs
  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q | node_ivalid;
    dup_err_d     = dup_err_q | (|(flags_q & node_ivalid));
    first_pass_d  = first_pass_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    done_op_d     = done_op_q;
    done_cycles_d = done_cycles_q;
    err_count_d   = err_count_q;
    cur_op_d      = cur_op_q;
    cur_size_d    = cur_size_q;
    cycles_d      = (busy_q && (cycles_q != '1)) ? cycles_q + 32'd1 : cycles_q;
    node_ovalid_d = '0;
    node_odata_d  = '0;
    pop           = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (&flags_d) begin
          if (first_pass_q) begin
            first_pass_d = 1'b0;
          end else begin
            done_d        = 1'b1;
            done_op_d     = cur_op_q;
            done_cycles_d = cycles_q;
            busy_d        = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_valid) begin
            flags_d       = '0;
            cur_op_d      = head_op;
            cur_size_d    = head_size;
            node_ovalid_d = '1;
            node_odata_d  = {N{WORD_W'(head_op)}};
            busy_d        = 1'b1;
            cycles_d      = 32'd1;
            state_d       = S_SEND_SIZE;
          end else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
      end
      S_SEND_SIZE: begin
        node_ovalid_d = '1;
        node_odata_d  = {N{WORD_W'(cur_size_q)}};
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_COLLECT;
      fifo_op_q     <= '{default: '0};
      fifo_size_q   <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_ready_q   <= 1'b0;
      flags_q       <= '0;
      first_pass_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_op_q     <= '0;
      done_cycles_q <= '0;
      err_count_q   <= '0;
      dup_err_q     <= 1'b0;
      cycles_q      <= '0;
      cur_op_q      <= '0;
      cur_size_q    <= '0;
      node_ovalid_q <= '0;
      node_odata_q  <= '0;
    end else begin
      state_q       <= state_d;
      fifo_op_q     <= fifo_op_d;
      fifo_size_q   <= fifo_size_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_ready_q   <= cmd_ready_d;
      flags_q       <= flags_d;
      first_pass_q  <= first_pass_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_op_q     <= done_op_d;
      done_cycles_q <= done_cycles_d;
      err_count_q   <= err_count_d;
      dup_err_q     <= dup_err_d;
      cycles_q      <= cycles_d;
      cur_op_q      <= cur_op_d;
      cur_size_q    <= cur_size_d;
      node_ovalid_q <= node_ovalid_d;
      node_odata_q  <= node_odata_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign node_ovalid = node_ovalid_q;
  assign node_odata  = node_odata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_op     = done_op_q;
  assign done_cycles = done_cycles_q;
  assign err_count   = err_count_q;
  assign dup_err     = dup_err_q;

endmodule

// File: tb/tb_collective_controller.sv
// Directed bench for collective_controller: command table plus hand-written
// sequences for queue backpressure, duplicate readies and mid-command reset.
module tb_collective_controller;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 128;
  localparam int unsigned D     = 5;
  localparam int unsigned DEPTH = 4;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_op;
  logic [31:0]      cmd_size;
  logic [N-1:0]     node_ivalid;
  logic [128*N-1:0] node_idata;
  logic [N-1:0]     node_ovalid;
  logic [0:128*N-1] node_odata;
  logic             busy;
  logic             done;
  logic [31:0]      done_op;
  logic [31:0]      done_cycles;
  logic [7:0]       err_count;
  logic             dup_err;

  collective_controller #(.N(N), .W(W), .D(D), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_size(cmd_size), .node_ivalid(node_ivalid),
    .node_idata(node_idata), .node_ovalid(node_ovalid), .node_odata(node_odata),
    .busy(busy), .done(done), .done_op(done_op), .done_cycles(done_cycles),
    .err_count(err_count), .dup_err(dup_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovalid_cycles = 0;

  always @(negedge clock) if (node_ovalid != '0) ovalid_cycles++;

  typedef struct {
    logic [31:0] op;
    logic [31:0] size;
    bit          ok;
    int          wait_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] slice(input int i);
    return node_odata[128*i +: 128];
  endfunction

  task automatic check_word(input string name, input logic [31:0] exp);
    for (int i = 0; i < int'(N); i++) check(name, slice(i), 128'(exp));
  endtask

  // One clock; a command offered on cmd_valid is withdrawn once accepted
  task automatic step();
    bit acc;
    acc = cmd_valid && cmd_ready;
    @(posedge clock);
    #1;
    cyc++;
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] op, input logic [31:0] size);
    cmd_op    = op;
    cmd_size  = size;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && cmd_valid; k++) step();
    check("push_accepted", cmd_valid, 1'b0);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_dispatch(input string name, input logic [31:0] op,
                                 input logic [31:0] size, output int start);
    for (int k = 0; k < 10 && node_ovalid == '0; k++) step();
    check({name, "_op_valid"}, node_ovalid, {N{1'b1}});
    check_word({name, "_op_word"}, op);
    check({name, "_busy"}, busy, 1'b1);
    start = cyc;
    step();
    check({name, "_size_valid"}, node_ovalid, {N{1'b1}});
    check_word({name, "_size_word"}, size);
    step();
    check({name, "_ovalid_low"}, node_ovalid, '0);
    check_word({name, "_odata_low"}, 32'd0);
  endtask

  task automatic complete(input string name, input logic [31:0] op, input int start,
                          input int wait_cyc);
    repeat (wait_cyc) step();
    check({name, "_no_early_done"}, done, 1'b0);
    node_ivalid = '1;
    step();
    node_ivalid = '0;
    check({name, "_done"}, done, 1'b1);
    check({name, "_done_op"}, done_op, op);
    check({name, "_done_cycles"}, done_cycles, 32'(cyc - start));
    check({name, "_busy_clear"}, busy, 1'b0);
    check({name, "_no_pop_with_done"}, node_ovalid, '0);
    step();
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int exp_err;
    int start;
    int oc;
    logic [31:0] q_op [5];
    logic [31:0] q_size [5];

    vecs[0] = '{32'd0, 32'd256,  1'b1, 20};
    vecs[1] = '{32'd2, 32'd64,   1'b0, 0};
    vecs[2] = '{32'd0, 32'd100,  1'b0, 0};
    vecs[3] = '{32'd1, 32'd2112, 1'b0, 0};
    vecs[4] = '{32'd1, 32'd64,   1'b1, 3};
    vecs[5] = '{32'd1, 32'd2048, 1'b1, 0};
    vecs[6] = '{32'd0, 32'd0,    1'b0, 0};
    vecs[7] = '{32'd0, 32'd1984, 1'b1, 7};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0;
    node_ivalid = '0; node_idata = '0;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_ovalid", node_ovalid, '0);
    check_word("rst_odata", 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_done_op", done_op, 32'd0);
    check("rst_done_cycles", done_cycles, 32'd0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_dup_err", dup_err, 1'b0);
    reset = 1'b1;
    step();
    check("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Initial readiness on staggered cycles must not produce a completion
    for (int i = 0; i < int'(N); i++) begin
      node_ivalid = N'(1) << i;
      step();
      node_ivalid = '0;
      check("first_pass_no_done", done, 1'b0);
      step();
    end
    check("idle_busy", busy, 1'b0);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("idle_no_dup", dup_err, 1'b0);

    exp_err = 0;
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].ok) begin
        push_cmd(vecs[v].op, vecs[v].size);
        expect_dispatch($sformatf("vec%0d", v), vecs[v].op, vecs[v].size, start);
        complete($sformatf("vec%0d", v), vecs[v].op, start, vecs[v].wait_cyc);
      end else begin
        oc = ovalid_cycles;
        push_cmd(vecs[v].op, vecs[v].size);
        step();
        exp_err++;
        step();
        step();
        check($sformatf("vec%0d_err_count", v), err_count, 8'(exp_err));
        check($sformatf("vec%0d_no_traffic", v), ovalid_cycles, oc);
        check($sformatf("vec%0d_not_busy", v), busy, 1'b0);
      end
    end

    // Fill the queue while a collective is outstanding, then drain in order
    push_cmd(32'd0, 32'd64);
    expect_dispatch("bb_a", 32'd0, 32'd64, start);
    for (int k = 0; k < 5; k++) begin
      q_op[k]   = 32'(k % 2);
      q_size[k] = 32'(64 * (k + 1));
    end
    for (int k = 0; k < 4; k++) push_cmd(q_op[k], q_size[k]);
    check("bb_full_ready_low", cmd_ready, 1'b0);
    cmd_op = q_op[4]; cmd_size = q_size[4]; cmd_valid = 1'b1;
    step();
    step();
    check("bb_fifth_held", cmd_valid, 1'b1);
    check("bb_still_busy", busy, 1'b1);
    complete("bb_a", 32'd0, start, 2);
    for (int k = 0; k < 5; k++) begin
      expect_dispatch($sformatf("bb%0d", k), q_op[k], q_size[k], start);
      complete($sformatf("bb%0d", k), q_op[k], start, 2 + k);
    end
    check("bb_drained_ready", cmd_ready, 1'b1);

    // Duplicate ready from node 2 flags an error but does not complete the collective
    check("dup_clear_before", dup_err, 1'b0);
    push_cmd(32'd1, 32'd128);
    expect_dispatch("dup", 32'd1, 32'd128, start);
    node_ivalid = 4'b0100; step(); node_ivalid = '0; step();
    node_ivalid = 4'b0100; step(); node_ivalid = '0;
    check("dup_err_set", dup_err, 1'b1);
    check("dup_no_done", done, 1'b0);
    node_ivalid = 4'b0001; step(); node_ivalid = '0;
    check("dup_wait_n1", done, 1'b0);
    node_ivalid = 4'b0010; step(); node_ivalid = '0;
    check("dup_wait_n3", done, 1'b0);
    node_ivalid = 4'b1000; step(); node_ivalid = '0;
    check("dup_done", done, 1'b1);
    check("dup_done_op", done_op, 32'd1);
    step();

    // Reset while the size word is pending drops everything, including queued commands
    push_cmd(32'd0, 32'd256);
    cmd_op = 32'd1; cmd_size = 32'd64; cmd_valid = 1'b1;
    step();
    check("mid_op_word_up", node_ovalid, {N{1'b1}});
    check("mid_second_queued", cmd_valid, 1'b0);
    reset = 1'b0;
    step();
    check("mid_rst_ovalid", node_ovalid, '0);
    check_word("mid_rst_odata", 32'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err_count, 8'd0);
    check("mid_rst_dup", dup_err, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b0);
    check("mid_rst_done", done, 1'b0);
    step();
    reset = 1'b1;
    step();
    oc = ovalid_cycles;
    node_ivalid = '1; step(); node_ivalid = '0;
    check("mid_reannounce_no_done", done, 1'b0);
    repeat (6) step();
    check("mid_queue_lost", ovalid_cycles, oc);
    check("mid_idle_busy", busy, 1'b0);
    check("mid_idle_ready", cmd_ready, 1'b1);
    push_cmd(32'd1, 32'd192);
    expect_dispatch("post_rst", 32'd1, 32'd192, start);
    complete("post_rst", 32'd1, start, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
